// File: rtl/digit_timer.sv
// rtl/digit_timer.sv - per-digit answer countdown timer with one-second prescaler
// Optional low-time warning output is built only when DIGIT_TIMER_WARN_EN is defined.
module digit_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int DIGIT_TIME    = 10,
  parameter int TW            = 6,
  parameter int WARN_SECS     = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Timer_enable,
  input  logic          Timer_reconfig,
  output logic          DigitTime_Out,
  output logic [TW-1:0] Time_Left,
  output logic          Time_Warn
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [TW-1:0] SEC_LOAD = TW'(DIGIT_TIME);

  if (TICKS_PER_SEC < 2 || DIGIT_TIME < 1 || DIGIT_TIME > (2**TW) - 1 || WARN_SECS < 0) begin : g_bad_cfg
    $error("digit_timer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] sec_q, sec_d;
  logic          exp_q, exp_d;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    sec_d   = sec_q;
    exp_d   = exp_q;
    if (Timer_reconfig) begin
      pre_d   = '0;
      sec_d   = SEC_LOAD;
      exp_d   = 1'b0;
      state_d = Timer_enable ? RUN : IDLE;
    end else if (state_q == EXPIRED) begin
      state_d = EXPIRED;
    end else if (!Timer_enable) begin
      state_d = IDLE;
    end else begin
      state_d = RUN;
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        // Guard keeps the seconds counter from wrapping below zero
        if (sec_q != '0) begin
          sec_d = sec_q - 1'b1;
        end
        if (sec_q == TW'(1)) begin
          state_d = EXPIRED;
          exp_d   = 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      sec_q   <= SEC_LOAD;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      exp_q   <= exp_d;
    end
  end

  assign DigitTime_Out = exp_q;
  assign Time_Left     = sec_q;

`ifdef DIGIT_TIMER_WARN_EN
  localparam logic [TW-1:0] WARN_LIM = (WARN_SECS >= (2**TW)) ? {TW{1'b1}} : TW'(WARN_SECS);

  logic warn_q, warn_d;

  // Computed from next-state values so the flag lines up with Time_Left
  always_comb begin
    warn_d = !Timer_reconfig && (state_d != EXPIRED) &&
             (sec_d != '0) && (sec_d <= WARN_LIM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign Time_Warn = warn_q;
`else
  assign Time_Warn = 1'b0;
`endif

endmodule
